// File: rtl/drive_split5_if.sv
// Drive/free handshake bundle for drive_split5: one upstream channel, five downstream channels.
// The slave modport is the splitter's view; master is the surrounding environment.
interface drive_split5_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_drive;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_free;
    logic                  o_drive0;
    logic                  o_drive1;
    logic                  o_drive2;
    logic                  o_drive3;
    logic                  o_drive4;
    logic [DATA_WIDTH-1:0] o_data;
    logic [2:0]            o_sel;
    logic                  i_free0;
    logic                  i_free1;
    logic                  i_free2;
    logic                  i_free3;
    logic                  i_free4;
    logic                  o_busy;
    logic                  o_err;

    modport slave (
        input  i_drive, i_data, i_free0, i_free1, i_free2, i_free3, i_free4,
        output o_free, o_drive0, o_drive1, o_drive2, o_drive3, o_drive4,
               o_data, o_sel, o_busy, o_err
    );

    modport master (
        output i_drive, i_data, i_free0, i_free1, i_free2, i_free3, i_free4,
        input  o_free, o_drive0, o_drive1, o_drive2, o_drive3, o_drive4,
               o_data, o_sel, o_busy, o_err
    );
endinterface

// File: rtl/drive_split5.sv
// 1-to-5 drive/free steering stage; destination taken from a 3-bit field of the token.
// Optional WAIT timeout compiled in with DRIVE_SPLIT5_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no token held, ready to capture on i_drive
// ISSUE   | o_drive[o_sel] pulsing this cycle
// WAIT    | waiting for i_free[o_sel] (or timeout)
// RELEASE | o_free pulsing this cycle, back to IDLE next
module drive_split5 #(
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_LSB        = DATA_WIDTH - 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rstn,
    drive_split5_if.slave      bus
);
    if (DATA_WIDTH < 4 || SEL_LSB < 0 || SEL_LSB + 2 > DATA_WIDTH - 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("drive_split5: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [2:0]            sel_q, sel_d;
    logic [4:0]            drive_q, drive_d;
    logic                  free_q, free_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    logic [2:0]            sel_in;
    logic [7:0]            free_ext;
    logic                  match_free;

    assign sel_in     = bus.i_data[SEL_LSB +: 3];
    assign free_ext   = {3'b000, bus.i_free4, bus.i_free3, bus.i_free2,
                         bus.i_free1, bus.i_free0};
    assign match_free = free_ext[sel_q];

`ifdef DRIVE_SPLIT5_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    assign cnt_inc = cnt_q + 16'd1;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        drive_d = 5'd0;
        free_d  = 1'b0;
        err_d   = 1'b0;
`ifdef DRIVE_SPLIT5_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.i_drive) begin
                    data_d = bus.i_data;
                    sel_d  = sel_in;
                    if (sel_in <= 3'd4) begin
                        state_d = S_ISSUE;
                        drive_d = 5'd1 << sel_in;
                    end else begin
                        // Out-of-range destination: drop token, release upstream with error.
                        state_d = S_RELEASE;
                        free_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef DRIVE_SPLIT5_TIMEOUT_EN
                cnt_d   = 16'd0;
`endif
            end
            S_WAIT: begin
                if (match_free) begin
                    state_d = S_RELEASE;
                    free_d  = 1'b1;
                end
`ifdef DRIVE_SPLIT5_TIMEOUT_EN
                else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_LIM) begin
                        state_d = S_RELEASE;
                        free_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A drive while busy is never captured; it only raises the error pulse.
        if (bus.i_drive && state_q != S_IDLE) begin
            err_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            sel_q   <= 3'd0;
            drive_q <= 5'd0;
            free_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DRIVE_SPLIT5_TIMEOUT_EN
            cnt_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            drive_q <= drive_d;
            free_q  <= free_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef DRIVE_SPLIT5_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.o_drive0 = drive_q[0];
    assign bus.o_drive1 = drive_q[1];
    assign bus.o_drive2 = drive_q[2];
    assign bus.o_drive3 = drive_q[3];
    assign bus.o_drive4 = drive_q[4];
    assign bus.o_free   = free_q;
    assign bus.o_err    = err_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_data   = data_q;
    assign bus.o_sel    = sel_q;
endmodule

// File: tb/tb_drive_split5.sv
// Scoreboard bench for drive_split5: stimulus pushes expected output events, a monitor pops and compares.
// Timeout scenarios are exercised when DRIVE_SPLIT5_TIMEOUT_EN is defined.
module tb_drive_split5;
    localparam int DW = 32;
    localparam int SL = DW - 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    drive_split5_if #(.DATA_WIDTH(DW)) bus();

    drive_split5 #(
        .DATA_WIDTH(DW),
        .SEL_LSB(SL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    typedef struct {
        int            cyc;
        logic [4:0]    drv;
        logic          fr;
        logic          er;
        logic [DW-1:0] data;
        logic [2:0]    sel;
    } ev_t;

    ev_t evq[$];
    bit  busy_exp[int];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_free(input logic [4:0] f);
        bus.i_free0 = f[0];
        bus.i_free1 = f[1];
        bus.i_free2 = f[2];
        bus.i_free3 = f[3];
        bus.i_free4 = f[4];
    endtask

    task automatic clear_inputs();
        bus.i_drive = 1'b0;
        bus.i_data  = '0;
        set_free(5'd0);
    endtask

    function automatic ev_t mk_ev(input int c, input logic [4:0] drv, input logic fr,
                                  input logic er, input logic [DW-1:0] data,
                                  input logic [2:0] sel);
        ev_t e;
        e.cyc = c; e.drv = drv; e.fr = fr; e.er = er; e.data = data; e.sel = sel;
        return e;
    endfunction

    // One token: d = WAIT cycles before the matching free, v_off >= 0 adds a
    // drive while busy at some cycle between ISSUE and RELEASE.
    task automatic run_token(input logic [2:0] sel, input logic [DW-1:0] raw,
                             input int d, input int v_off);
        int t, u, v, rel, last;
        logic timed;
        logic [DW-1:0] data;
        logic [4:0] f;
        ev_t er;
        data = raw;
        data[SL +: 3] = sel;
        t = cyc;
        u = -1;
        v = -1;
        timed = 1'b0;
        if (sel > 3'd4) begin
            rel = t + 1;
            evq.push_back(mk_ev(t + 1, 5'd0, 1'b1, 1'b1, data, sel));
            if (v_off >= 0) begin
                v = t + 1;
                evq.push_back(mk_ev(v + 1, 5'd0, 1'b0, 1'b1, data, sel));
            end
        end else begin
            u = t + 2 + d;
            rel = u + 1;
`ifdef DRIVE_SPLIT5_TIMEOUT_EN
            if (d >= TO) begin
                rel = t + 2 + TO;
                timed = 1'b1;
            end
`endif
            evq.push_back(mk_ev(t + 1, 5'd1 << sel, 1'b0, 1'b0, data, sel));
            er = mk_ev(rel, 5'd0, 1'b1, timed, data, sel);
            if (v_off >= 0) v = t + 1 + (v_off % (rel - t));
            if (v < 0) begin
                evq.push_back(er);
            end else if (v + 1 < rel) begin
                evq.push_back(mk_ev(v + 1, 5'd0, 1'b0, 1'b1, data, sel));
                evq.push_back(er);
            end else if (v + 1 == rel) begin
                er.er = 1'b1;
                evq.push_back(er);
            end else begin
                evq.push_back(er);
                evq.push_back(mk_ev(v + 1, 5'd0, 1'b0, 1'b1, data, sel));
            end
        end
        for (int c = t + 1; c <= rel; c++) busy_exp[c] = 1'b1;
        last = rel;
        if (v > last) last = v;
        if (u > last) last = u;
        for (int c = t; c <= last; c++) begin
            bus.i_drive = (c == t) || (c == v);
            bus.i_data  = (c == t) ? data : DW'($urandom);
            f = 5'($urandom);
            if (sel <= 3'd4) begin
                if (c >= t + 2 && c < u) f = f & ~(5'd1 << sel);
                if (c == u) f = f | (5'd1 << sel);
            end
            set_free(f);
            tick();
        end
        clear_inputs();
    endtask

    always @(negedge clk) begin
        logic [4:0] drv;
        ev_t e;
        logic be;
        if (mon_en) begin
            drv = {bus.o_drive4, bus.o_drive3, bus.o_drive2, bus.o_drive1, bus.o_drive0};
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event at cyc %0d: got no output, required event of cyc %0d",
                         cyc, evq[0].cyc);
                void'(evq.pop_front());
            end
            if (drv !== 5'd0 || bus.o_free !== 1'b0 || bus.o_err !== 1'b0) begin
                checks++;
                if (evq.size() == 0 || evq[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected_output cyc %0d: got drv=%b free=%b err=%b, required none",
                             cyc, drv, bus.o_free, bus.o_err);
                end else begin
                    e = evq.pop_front();
                    if (drv !== e.drv || bus.o_free !== e.fr || bus.o_err !== e.er ||
                        bus.o_data !== e.data || bus.o_sel !== e.sel) begin
                        errors++;
                        $display("FAIL event cyc %0d: got drv=%b free=%b err=%b data=%h sel=%0d required drv=%b free=%b err=%b data=%h sel=%0d",
                                 cyc, drv, bus.o_free, bus.o_err, bus.o_data, bus.o_sel,
                                 e.drv, e.fr, e.er, e.data, e.sel);
                    end
                end
            end
            be = busy_exp.exists(cyc) ? 1'b1 : 1'b0;
            checks++;
            if (bus.o_busy !== be) begin
                errors++;
                $display("FAIL busy cyc %0d: got %b required %b", cyc, bus.o_busy, be);
            end
        end
    end

    initial begin
        int t;
        logic [2:0] s;
        logic [DW-1:0] data;
        clear_inputs();
        rstn = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        checks++;
        if (bus.o_data !== '0 || bus.o_sel !== 3'd0 || bus.o_free !== 1'b0 ||
            bus.o_err !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got data=%h sel=%0d free=%b err=%b busy=%b required all zero",
                     bus.o_data, bus.o_sel, bus.o_free, bus.o_err, bus.o_busy);
        end
        rstn = 1'b1;
        tick();

        run_token(3'd3, 32'h6000_00AB, 2, -1);
        for (int k = 0; k < 5; k++) run_token(3'(k), DW'($urandom), 0, -1);
        run_token(3'd6, DW'($urandom), 0, -1);
        tick();
        run_token(3'd1, DW'($urandom), 4, 1);
        run_token(3'd7, DW'($urandom), 0, 0);

        // Reset while waiting: token discarded, no release or error afterwards.
        t = cyc;
        data = DW'($urandom);
        data[SL +: 3] = 3'd4;
        evq.push_back(mk_ev(t + 1, 5'd16, 1'b0, 1'b0, data, 3'd4));
        for (int c = t + 1; c <= t + 3; c++) busy_exp[c] = 1'b1;
        bus.i_drive = 1'b1;
        bus.i_data  = data;
        tick();
        clear_inputs();
        tick();
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++;
        if (bus.o_data !== '0 || bus.o_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_midflight: got data=%h sel=%0d required 0 0", bus.o_data, bus.o_sel);
        end
        tick();
        tick();
        run_token(3'd0, DW'($urandom), 1, -1);

`ifdef DRIVE_SPLIT5_TIMEOUT_EN
        run_token(3'd2, DW'($urandom), TO - 1, -1);
        run_token(3'd2, DW'($urandom), TO, -1);
        run_token(3'd1, DW'($urandom), TO + 3, -1);
        run_token(3'd3, DW'($urandom), TO + 1, 5);
`endif

        for (int n = 0; n < 150; n++) begin
            s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
`ifdef DRIVE_SPLIT5_TIMEOUT_EN
            run_token(s, DW'($urandom), int'($urandom_range(0, TO + 3)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1);
`else
            run_token(s, DW'($urandom), int'($urandom_range(0, 6)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1);
`endif
            repeat ($urandom_range(0, 2)) begin
                set_free(5'($urandom));
                tick();
            end
            clear_inputs();
        end

        repeat (5) tick();
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending, required 0", evq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/drive_split5.md
# drive_split5

Synchronous 1-to-5 steering stage for the drive/free token handshake. It is the counterpart of the 5-to-1 mutex merge: it accepts one token on a single upstream drive/free channel and routes it to one of five downstream drive/free channels. The destination is taken from a select field carried in the token data. It sits at fan-out points of the clocked datapath, for example when returning results from a shared unit to per-lane consumers. One token is in flight at a time.

## Interface
Parameters:
- DATA_WIDTH, 32, token payload width in bits; minimum 4.
- SEL_LSB, DATA_WIDTH-3, LSB position of the 3-bit destination field in i_data; SEL_LSB+2 must be at most DATA_WIDTH-1.
- TIMEOUT_CYCLES, 255, wait limit used only when the timeout feature is compiled in; range 1..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  synchronous, active-low reset.
- i_drive  in  1  upstream token-valid pulse, one cycle wide.
- i_data  in  DATA_WIDTH  upstream payload; sampled only in the cycle i_drive is high.
- o_free  out  1  upstream release pulse, one cycle wide.
- o_drive0..o_drive4  out  1 each  downstream token pulses, one cycle wide.
- o_data  out  DATA_WIDTH  registered payload, shared by all five outputs.
- o_sel  out  3  registered destination index.
- i_free0..i_free4  in  1 each  downstream release pulses.
- o_busy  out  1  high while a token is held.
- o_err  out  1  one-cycle error pulse.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RELEASE.
- IDLE, i_drive=1:
  - Register i_data into o_data and i_data[SEL_LSB+2:SEL_LSB] into o_sel.
  - If sel is 0..4, go to ISSUE.
  - If sel is 5..7, go to RELEASE and pulse o_err in that same next cycle. No o_driveK is asserted and the token is dropped.
- ISSUE: assert o_drive[o_sel] for exactly one cycle, then go to WAIT. Any i_freeK seen during ISSUE is ignored.
- WAIT: when i_free[o_sel]=1, go to RELEASE. i_free on any other channel is ignored, with no error.
- RELEASE: assert o_free for one cycle, then go to IDLE.
- i_drive while state≠IDLE is a protocol violation. The token is not captured and o_err pulses in the next cycle. The current transaction continues unaffected.
- If both violation errors fall in the same cycle, they merge into a single o_err pulse.
- o_data and o_sel stay stable from the capture cycle until the next capture. They are not cleared on release.
- o_busy = (state≠IDLE).
- Reset values:
  - state IDLE.
  - o_drive0..4=0, o_free=0, o_err=0, o_busy=0.
  - o_data=0, o_sel=0.
  - Timeout counter = 0.
- rstn low in any state forces reset values in the next cycle. An in-flight token is discarded, and neither o_free nor o_err is generated for it.

## Timing
- i_drive at cycle t gives o_driveK at t+1.
- i_freeK at cycle u ≥ t+2 gives o_free at u+1.
- Minimum round trip is i_drive at t to o_free at t+3, when i_freeK arrives at t+2.
- Invalid select: i_drive at t gives o_free and o_err both at t+1.
- Back-to-back: the earliest next accepted i_drive is the cycle after o_free, because state is IDLE in that cycle. i_drive in the RELEASE cycle itself is a violation.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- DRIVE_SPLIT5_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle with no matching free.
  - When the counter reaches TIMEOUT_CYCLES, the block goes to RELEASE, and o_free and o_err pulse together.
  - A matching i_freeK arriving in the same cycle the counter reaches the limit wins: release happens normally with no o_err.
  - A matching free arriving after a timeout is ignored.
- DRIVE_SPLIT5_TIMEOUT_EN undefined: the block waits in WAIT indefinitely. No counter is instantiated.

## Test plan
- Routing: i_drive with sel=3 and data 0x6000_00AB at t → o_drive3=1 at t+1 with o_data=0x6000_00AB, o_sel=3. Apply i_free3 at t+4 → o_free at t+5. No other o_driveK asserted.
- All channels: five sequential tokens with sel=0..4 → each o_driveK fires exactly once, in order. o_busy is low for exactly one cycle between tokens when i_drive is applied immediately after o_free.
- Invalid select: sel=6 at t → o_free=1 and o_err=1 at t+1; no o_driveK; o_busy low at t+2.
- Violations: token to ch1, then i_drive during WAIT → o_err one-cycle pulse, second token not captured. i_free2 during WAIT → ignored. i_free1 → normal release.
- Reset mid-flight: rstn low one cycle during WAIT → all outputs at reset values the next cycle, no o_free. A following token on ch0 completes normally.
- Timeout (macro on, TIMEOUT_CYCLES=8): no free returned → o_free and o_err at the cycle the counter hits 8, then IDLE. A late i_freeK is ignored. Free arriving at count 8 → release with no o_err.
